collect_2x1_src_tag_seq: RTL

Registered 2-to-1 collection switch: the upstream counterpart of the 1x2 destination-tag distribute switch. Two input streams compete for one output under valid/ready handshaking. A round-robin arbiter picks the winner each cycle, and the winner's data is captured in a single output pipeline register. The winner's index is prepended to its tag as the new MSB, so a chain of these switches rebuilds the destination tag that a distribute tree later consumes MSB-first.

---
 rtl/collect_2x1_src_tag_seq_if.sv | 26 ++
 rtl/collect_2x1_src_tag_seq.sv | 69 ++++++
 2 files changed

// File: rtl/collect_2x1_src_tag_seq_if.sv
// Handshake bundle between the 2-to-1 source-tag collection switch and its neighbours.
// master drives the two input streams and downstream ready; slave is the switch.
interface collect_2x1_src_tag_seq_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int SRC_TAG_WIDTH = 1
);
    logic [1:0]                 i_valid;
    logic [2*DATA_WIDTH-1:0]    i_data_bus;
    logic [2*SRC_TAG_WIDTH-1:0] i_cmd;
    logic [1:0]                 o_ready;
    logic                       i_en;
    logic                       o_valid;
    logic [DATA_WIDTH-1:0]      o_data_bus;
    logic [SRC_TAG_WIDTH:0]     o_cmd;
    logic                       i_ready;

    modport master (
        output i_valid, i_data_bus, i_cmd, i_en, i_ready,
        input  o_ready, o_valid, o_data_bus, o_cmd
    );

    modport slave (
        input  i_valid, i_data_bus, i_cmd, i_en, i_ready,
        output o_ready, o_valid, o_data_bus, o_cmd
    );
endinterface

// File: rtl/collect_2x1_src_tag_seq.sv
// Registered 2-to-1 collection switch; the winner index becomes the new tag MSB.
// Build option: define ROUND_ROBIN_EN for round-robin arbitration, otherwise high input has fixed priority.
//
// state (out_valid_r) | meaning
// 0                   | output register empty, outputs driven to z
// 1                   | output register holds a word waiting for i_ready
module collect_2x1_src_tag_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int SRC_TAG_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    collect_2x1_src_tag_seq_if.slave      bus
);
    logic                     out_valid_r;
    logic [DATA_WIDTH-1:0]    out_data_r;
    logic [SRC_TAG_WIDTH:0]   out_cmd_r;

    logic                     win_hi;
    logic                     load;
    logic [DATA_WIDTH-1:0]    win_data;
    logic [SRC_TAG_WIDTH-1:0] win_cmd;

`ifdef ROUND_ROBIN_EN
    logic rr_ptr;

    // rr_ptr only matters when both inputs request
    assign win_hi = bus.i_valid[1] && (!bus.i_valid[0] || rr_ptr);
`else
    assign win_hi = bus.i_valid[1];
`endif

    // rst_n gates load so nothing is offered while reset is held
    assign load = rst_n && bus.i_en && (!out_valid_r || bus.i_ready) && (|bus.i_valid);

    assign win_data = win_hi ? bus.i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                             : bus.i_data_bus[DATA_WIDTH-1:0];
    assign win_cmd  = win_hi ? bus.i_cmd[2*SRC_TAG_WIDTH-1:SRC_TAG_WIDTH]
                             : bus.i_cmd[SRC_TAG_WIDTH-1:0];

    assign bus.o_ready = {load && win_hi, load && !win_hi};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= 1'b0;
`endif
        end else if (load) begin
            out_valid_r <= 1'b1;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= ~win_hi;
`endif
        end else if (bus.i_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            out_data_r <= win_data;
            out_cmd_r  <= {win_hi, win_cmd};
        end
    end

    assign bus.o_valid    = out_valid_r;
    assign bus.o_data_bus = out_valid_r ? out_data_r : {DATA_WIDTH{1'bz}};
    assign bus.o_cmd      = out_valid_r ? out_cmd_r  : {(SRC_TAG_WIDTH+1){1'bz}};
endmodule
